i2c_fifo_pair_sync: RTL
=======================

Name: i2c_fifo_pair_sync

Overview:
Parametrised next-generation TX/RX data FIFO pair for the I2C controller. Both FIFOs run on a single clock domain.
- TX FIFO: APB-side writes, core-side reads.
- RX FIFO: core-side writes, APB-side reads.
- Adds configurable width and depth, programmable watermarks, fill-level outputs, per-channel flush, and sticky overflow/underflow error flags.
- Sits between the APB register block and the I2C datapath.

Parameters:
DATA_WIDTH, 8, width of each FIFO entry
ADDR_SIZE, 4, pointer width; DEPTH = 2**ADDR_SIZE entries per FIFO

Ports:
pclk_i  in  1  single clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
tx_flush_i  in  1  empty the TX FIFO
rx_flush_i  in  1  empty the RX FIFO
tx_wr_en_i  in  1  push tx_wdata_i into TX
tx_wdata_i  in  DATA_WIDTH  TX write data (from APB)
tx_rd_en_i  in  1  pop from TX (datapath side)
tx_rdata_o  out  DATA_WIDTH  TX read data (to SDA datapath)
rx_wr_en_i  in  1  push rx_wdata_i into RX
rx_wdata_i  in  DATA_WIDTH  RX write data (from SDA datapath)
rx_rd_en_i  in  1  pop from RX (APB side)
rx_rdata_o  out  DATA_WIDTH  RX read data (to APB)
afull_thr_i  in  ADDR_SIZE+1  almost-full threshold, shared by both FIFOs
aempty_thr_i  in  ADDR_SIZE+1  almost-empty threshold, shared by both FIFOs
err_clr_i  in  1  clear all sticky error flags
tx_level_o  out  ADDR_SIZE+1  TX fill count, 0..DEPTH
rx_level_o  out  ADDR_SIZE+1  RX fill count, 0..DEPTH
status_o  out  8  [7] tx_empty, [6] tx_full, [5] tx_aempty, [4] tx_afull, [3] rx_empty, [2] rx_full, [1] rx_aempty, [0] rx_afull
err_o  out  4  [3] tx_ovf, [2] tx_udf, [1] rx_ovf, [0] rx_udf (sticky)

Behaviour:
- Clocking and reset: one clock, pclk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - Pointers, levels and rdata_o go to 0; err_o goes to 0.
  - status_o goes to 8'hAA when afull_thr_i != 0.
  - Memory contents are not reset.
- Both FIFOs behave identically; rules below apply per FIFO.
- Status decode (combinational from the registered level):
  - empty = (level == 0)
  - full = (level == DEPTH)
  - aempty = (level <= aempty_thr_i)
  - afull = (level >= afull_thr_i)
- Accepted write: wr_en && !full. Data is stored at the write pointer, which increments modulo DEPTH; level increments.
- Accepted read: rd_en && !empty. Read pointer increments modulo DEPTH; level decrements.
- Write latency: data written in cycle N is readable from N+1; empty deasserts in N+1.
- Read latency (default mode): rdata_o is registered and updates in the cycle after an accepted read. It holds its value until the next accepted read.
- Simultaneous read and write when 0 < level < DEPTH: both are accepted and level is unchanged.
- Simultaneous read and write when full: both are accepted (no overflow) and level stays DEPTH.
- Simultaneous read and write when empty: the write is accepted, the read is rejected, and udf is set.
- Overflow: write while full (and no same-cycle read) is dropped; ovf is set; pointers and level are unchanged.
- Underflow: read while empty is ignored; udf is set; rdata_o holds.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 with no data corruption. Level is tracked separately, so full and empty are never ambiguous.
- Flush:
  - Next cycle: pointers and level go to 0.
  - Takes priority over same-cycle wr_en/rd_en, which are discarded without setting error flags.
  - err_o and rdata_o are unaffected.
- Error flags:
  - Cleared by err_clr_i.
  - If a new error and err_clr_i occur in the same cycle, the flag ends up set.
- Reset priority: rst_i overrides flush, writes and reads. Reset asserted mid-stream empties both FIFOs on the next edge.

Optional Feature:
Macro: I2C_FIFO_FWFT_EN
- Defined (first-word fall-through):
  - rdata_o continuously shows the head entry while the FIFO is not empty.
  - rd_en acknowledges and advances to the next entry.
  - When empty, rdata_o is 0.
  - A write into an empty FIFO appears on rdata_o in the cycle after the write.
- Undefined: registered one-cycle read latency, as described in Behaviour.

Test Plan:
- Reset then idle, afull_thr=14, aempty_thr=2 -> status_o=8'hAA, levels 0, err_o=0.
- Write 16 bytes 0x00..0x0F to TX, then a 17th write of 0xFF -> full=1 and tx_ovf=1 after the 17th; reading 16 entries returns 0x00..0x0F in order, with 0xFF absent.
- Push 20 bytes through RX with interleaved reads so pointers wrap -> output order matches input exactly; rx_level_o peaks and returns to 0; no error flags.
- Read from empty RX -> rx_udf=1 and rx_rdata_o unchanged; assert err_clr_i for one cycle -> err_o=0.
- Fill TX to level 8, then assert tx_flush_i together with tx_wr_en_i -> tx_level_o=0 and tx_empty=1 next cycle; no ovf set.
- With the FIFO full, assert wr_en and rd_en in the same cycle -> level stays 16, no ovf, the oldest entry is popped; repeat with I2C_FIFO_FWFT_EN defined and check head data is visible without a read.

Source files
------------

// File: rtl/i2c_fifo_pair_sync.sv
// i2c_fifo_pair_sync: TX/RX data FIFO pair between the APB register block and
// the I2C datapath. One clock, synchronous active-high reset.
// Optional macro I2C_FIFO_FWFT_EN: when defined, rdata shows the head entry
// (first-word fall-through); otherwise rdata is registered with one-cycle latency.

module i2c_fifo_ch #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rdata_o,
  input  logic [AW:0]   afull_thr_i,
  input  logic [AW:0]   aempty_thr_i,
  input  logic          err_clr_i,
  output logic [AW:0]   level_o,
  output logic [3:0]    status_o,
  output logic          ovf_o,
  output logic          udf_o
);
  localparam int DEPTH = 2**AW;
  localparam logic [AW:0]   DEPTH_L = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          empty, full, wr_acc, rd_acc;

  assign empty  = (level_q == '0);
  assign full   = (level_q == DEPTH_L);
  // A read frees a slot in the same cycle, so a write while full is accepted if paired with a read.
  assign rd_acc = !flush_i && rd_en_i && !empty;
  assign wr_acc = !flush_i && wr_en_i && (!full || rd_en_i);

  // Next-state for pointers, fill level and sticky error flags
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PTR_ONE;
      if (rd_acc) rptr_d = rptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
    // A new error in the same cycle as a clear wins.
    ovf_d = (ovf_q && !err_clr_i) || (!flush_i && wr_en_i && full && !rd_en_i);
    udf_d = (udf_q && !err_clr_i) || (!flush_i && rd_en_i && empty);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wptr_q] <= wdata_i;
  end

`ifdef I2C_FIFO_FWFT_EN
  assign rdata_o = empty ? '0 : mem_q[rptr_q];
`else
  logic [DW-1:0] rdata_q, rdata_d;

  // Read data captures the head entry on an accepted read and otherwise holds
  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = mem_q[rptr_q];
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
`endif

  assign level_o  = level_q;
  assign status_o = {empty, full, (level_q <= aempty_thr_i), (level_q >= afull_thr_i)};
  assign ovf_o    = ovf_q;
  assign udf_o    = udf_q;
endmodule

module i2c_fifo_pair_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 4
) (
  input  logic                  pclk_i,
  input  logic                  rst_i,
  input  logic                  tx_flush_i,
  input  logic                  rx_flush_i,
  input  logic                  tx_wr_en_i,
  input  logic [DATA_WIDTH-1:0] tx_wdata_i,
  input  logic                  tx_rd_en_i,
  output logic [DATA_WIDTH-1:0] tx_rdata_o,
  input  logic                  rx_wr_en_i,
  input  logic [DATA_WIDTH-1:0] rx_wdata_i,
  input  logic                  rx_rd_en_i,
  output logic [DATA_WIDTH-1:0] rx_rdata_o,
  input  logic [ADDR_SIZE:0]    afull_thr_i,
  input  logic [ADDR_SIZE:0]    aempty_thr_i,
  input  logic                  err_clr_i,
  output logic [ADDR_SIZE:0]    tx_level_o,
  output logic [ADDR_SIZE:0]    rx_level_o,
  output logic [7:0]            status_o,
  output logic [3:0]            err_o
);
  logic [3:0] tx_st, rx_st;
  logic       tx_ovf, tx_udf, rx_ovf, rx_udf;

  i2c_fifo_ch #(.DW(DATA_WIDTH), .AW(ADDR_SIZE)) u_tx (
    .clk(pclk_i), .rst(rst_i), .flush_i(tx_flush_i),
    .wr_en_i(tx_wr_en_i), .wdata_i(tx_wdata_i), .rd_en_i(tx_rd_en_i), .rdata_o(tx_rdata_o),
    .afull_thr_i(afull_thr_i), .aempty_thr_i(aempty_thr_i), .err_clr_i(err_clr_i),
    .level_o(tx_level_o), .status_o(tx_st), .ovf_o(tx_ovf), .udf_o(tx_udf)
  );

  i2c_fifo_ch #(.DW(DATA_WIDTH), .AW(ADDR_SIZE)) u_rx (
    .clk(pclk_i), .rst(rst_i), .flush_i(rx_flush_i),
    .wr_en_i(rx_wr_en_i), .wdata_i(rx_wdata_i), .rd_en_i(rx_rd_en_i), .rdata_o(rx_rdata_o),
    .afull_thr_i(afull_thr_i), .aempty_thr_i(aempty_thr_i), .err_clr_i(err_clr_i),
    .level_o(rx_level_o), .status_o(rx_st), .ovf_o(rx_ovf), .udf_o(rx_udf)
  );

  assign status_o = {tx_st, rx_st};
  assign err_o    = {tx_ovf, tx_udf, rx_ovf, rx_udf};
endmodule
